// File: rtl/entry_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : entry_conditioner_pkg
//  Brief    : Shared state encoding and constants for the entry conditioner.
//  Revision : 1.0 - initial release
// ============================================================================
package entry_conditioner_pkg;

    // Production debounce length (stable samples to accept an edge)
    localparam int c_DEBOUNCE_CYCLES = 50000;

    // Width of one keyed digit
    localparam int c_DIGIT_W = 4;

    // Conditioner FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS_DEB = 3'd1,
        ST_PULSE     = 3'd2,
        ST_HELD      = 3'd3,
        ST_REL_DEB   = 3'd4
    } state_t;

endpackage : entry_conditioner_pkg
`default_nettype wire

// File: rtl/entry_conditioner_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : entry_conditioner_sync2
//  Brief    : Parameterized-width two-flop synchronizer, async active-low reset.
//  Revision : 1.0 - initial release
// ============================================================================
module entry_conditioner_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops absorb metastability from the asynchronous input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : entry_conditioner_sync2
`default_nettype wire

// File: rtl/entry_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : entry_conditioner
//  Brief    : Debounces the raw active-low entry button into a single-cycle
//             strobe and captures the digit switches on that strobe.
//             Optional macro ENTRY_ECHO_EN adds the echo/digit_cnt display
//             history outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module entry_conditioner
    import entry_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_n,
    input  logic [c_DIGIT_W-1:0] swt_in,
    output logic                 b_out,
    output logic [c_DIGIT_W-1:0] swt_out,
    output logic                 busy
`ifdef ENTRY_ECHO_EN
    ,
    output logic [15:0]          echo,
    output logic [2:0]           digit_cnt
`endif
);

    // Last count value before a debounce state exits; the counter never wraps
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 w_btn_s;
    logic [c_DIGIT_W-1:0] w_swt_s;
    logic                 w_cnt_last;
    logic                 w_strobe;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_b_out;
    logic [c_DIGIT_W-1:0] r_swt_out;

    // Button is inverted before synchronizing so reset means "not pressed"
    entry_conditioner_sync2 #(
        .WIDTH (1)
    ) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d   (~btn_n),
        .q   (w_btn_s)
    );

    entry_conditioner_sync2 #(
        .WIDTH (c_DIGIT_W)
    ) u_sync_swt (
        .clk (clk),
        .rst (rst),
        .d   (swt_in),
        .q   (w_swt_s)
    );

    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    assign w_strobe   = (r_state == ST_PRESS_DEB) && w_btn_s && w_cnt_last;

    // Debounce FSM: accept press, emit one strobe, then debounce the release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_b_out   <= 1'b0;
            r_swt_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_btn_s) begin
                        r_cnt   <= '0;
                        r_state <= ST_PRESS_DEB;
                    end
                end
                ST_PRESS_DEB: begin
                    if (!w_btn_s) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_cnt_last) begin
                            r_state   <= ST_PULSE;
                            r_b_out   <= 1'b1;
                            r_swt_out <= w_swt_s;
                        end
                    end
                end
                ST_PULSE: begin
                    r_b_out <= 1'b0;
                    r_state <= ST_HELD;
                end
                ST_HELD: begin
                    if (!w_btn_s) begin
                        r_cnt   <= '0;
                        r_state <= ST_REL_DEB;
                    end
                end
                ST_REL_DEB: begin
                    if (w_btn_s) begin
                        r_state <= ST_HELD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_cnt_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_b_out <= 1'b0;
                end
            endcase
        end
    end

    assign b_out   = r_b_out;
    assign swt_out = r_swt_out;
    assign busy    = (r_state != ST_IDLE);

`ifdef ENTRY_ECHO_EN
    logic [15:0] r_echo;
    logic [2:0]  r_digit_cnt;

    // Digit history: shift in each strobed nibble, restart after four digits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_echo      <= '0;
            r_digit_cnt <= '0;
        end else if (w_strobe) begin
            if (r_digit_cnt == 3'd4) begin
                r_echo      <= {12'h000, w_swt_s};
                r_digit_cnt <= 3'd1;
            end else begin
                r_echo      <= {r_echo[11:0], w_swt_s};
                r_digit_cnt <= r_digit_cnt + 3'd1;
            end
        end
    end

    assign echo      = r_echo;
    assign digit_cnt = r_digit_cnt;
`endif

endmodule : entry_conditioner
`default_nettype wire

// File: tb/tb_entry_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_entry_conditioner
//  Brief    : Self-checking bench for entry_conditioner (DEBOUNCE_CYCLES=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_entry_conditioner;

    localparam int DEB = 8;
    // Inputs driven 1 time unit after edge N are first sampled at edge N+1;
    // the strobe is registered DEB+2 edges after that.
    localparam int LAT = DEB + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_n = 1'b1;
    logic [3:0] swt_in = 4'h0;
    logic       b_out;
    logic [3:0] swt_out;
    logic       busy;
`ifdef ENTRY_ECHO_EN
    logic [15:0] echo;
    logic [2:0]  digit_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [3:0] q_digit[$];
    int         q_cyc[$];
    logic       prev_b = 1'b0;
    logic [3:0] m_digit;
    int         m_cyc;

    entry_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .swt_in    (swt_in),
        .b_out     (b_out),
        .swt_out   (swt_out),
        .busy      (busy)
`ifdef ENTRY_ECHO_EN
        ,
        .echo      (echo),
        .digit_cnt (digit_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard: each observed strobe is matched against the oldest expected one
    always @(negedge clk) begin
        if (b_out === 1'b1) begin
            n_cmp++;
            if (prev_b === 1'b1) begin
                n_fail++;
                $display("FAIL strobe_width: b_out high two cycles running at cycle %0d, required single cycle", cyc);
            end
            if (q_digit.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: strobe seen at cycle %0d swt_out=%h, required no strobe", cyc, swt_out);
            end else begin
                m_digit = q_digit.pop_front();
                m_cyc   = q_cyc.pop_front();
                if (swt_out !== m_digit || cyc != m_cyc) begin
                    n_fail++;
                    $display("FAIL strobe: got swt_out=%h at cycle %0d, required swt_out=%h at cycle %0d",
                             swt_out, cyc, m_digit, m_cyc);
                end
            end
        end
        prev_b = b_out;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] d, input int c);
        q_digit.push_back(d);
        q_cyc.push_back(c);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    // Clean press of a digit: expected strobe queued, held, released, idle awaited
    task automatic press_release(input logic [3:0] d, input int hold, output bit ok);
        swt_in = d;
        tick(2);
        btn_n = 1'b0;
        push_exp(d, cyc + LAT);
        tick(hold);
        btn_n = 1'b1;
        wait_idle(ok);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        btn_n = 1'b1;
        swt_in = 4'h0;
        tick(3);
        n_cmp++;
        if (b_out !== 1'b0) begin n_fail++; $display("FAIL reset_b_out: got %b, required 0", b_out); end
        n_cmp++;
        if (swt_out !== 4'h0) begin n_fail++; $display("FAIL reset_swt_out: got %h, required 0", swt_out); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_clean_press;
        bit ok;
        swt_in = 4'hA;
        tick(2);
        btn_n = 1'b0;
        push_exp(4'hA, cyc + LAT);
        tick(40);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL clean_busy_held: got %b, required 1", busy); end
        btn_n = 1'b1;
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL clean_idle: busy=%b after 200 cycles, required 0", busy); end
        n_cmp++;
        if (q_digit.size() != 0) begin n_fail++; $display("FAIL clean_pending: %0d strobes missing, required 0", q_digit.size()); end
        n_cmp++;
        if (swt_out !== 4'hA) begin n_fail++; $display("FAIL clean_swt_out: got %h, required a", swt_out); end
    endtask

    task automatic test_bounce;
        bit ok;
        swt_in = 4'h5;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            btn_n = 1'b0;
            tick(3);
            btn_n = 1'b1;
            tick(3);
        end
        n_cmp++;
        if (swt_out !== 4'hA) begin n_fail++; $display("FAIL bounce_no_capture: got %h, required a", swt_out); end
        btn_n = 1'b0;
        push_exp(4'h5, cyc + LAT);
        tick(30);
        btn_n = 1'b1;
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL bounce_idle: busy=%b after 200 cycles, required 0", busy); end
        n_cmp++;
        if (q_digit.size() != 0) begin n_fail++; $display("FAIL bounce_pending: %0d strobes missing, required 0", q_digit.size()); end
        n_cmp++;
        if (swt_out !== 4'h5) begin n_fail++; $display("FAIL bounce_swt_out: got %h, required 5", swt_out); end
    endtask

    task automatic test_switch_change;
        bit ok;
        swt_in = 4'h3;
        tick(2);
        btn_n = 1'b0;
        push_exp(4'h3, cyc + LAT);
        tick(20);
        swt_in = 4'hC;
        tick(10);
        n_cmp++;
        if (swt_out !== 4'h3) begin n_fail++; $display("FAIL swchg_held: got %h, required 3", swt_out); end
        btn_n = 1'b1;
        wait_idle(ok);
        swt_in = 4'h9;
        tick(6);
        swt_in = 4'hC;
        tick(4);
        n_cmp++;
        if (!ok || swt_out !== 4'h3) begin
            n_fail++;
            $display("FAIL swchg_after_release: got swt_out=%h idle_ok=%0d, required 3 and 1", swt_out, ok);
        end
        press_release(4'hC, 20, ok);
        n_cmp++;
        if (!ok || q_digit.size() != 0 || swt_out !== 4'hC) begin
            n_fail++;
            $display("FAIL swchg_second: got swt_out=%h pending=%0d idle_ok=%0d, required c 0 1",
                     swt_out, q_digit.size(), ok);
        end
    endtask

    task automatic test_release_bounce;
        bit ok;
        swt_in = 4'h6;
        tick(2);
        btn_n = 1'b0;
        push_exp(4'h6, cyc + LAT);
        tick(20);
        for (int i = 0; i < 3; i++) begin
            btn_n = 1'b1;
            tick(3);
            btn_n = 1'b0;
            tick(3);
        end
        btn_n = 1'b1;
        tick(2);
        wait_idle(ok);
        n_cmp++;
        if (!ok || q_digit.size() != 0 || swt_out !== 4'h6) begin
            n_fail++;
            $display("FAIL relbounce_first: got swt_out=%h pending=%0d idle_ok=%0d, required 6 0 1",
                     swt_out, q_digit.size(), ok);
        end
        press_release(4'h2, 20, ok);
        n_cmp++;
        if (!ok || q_digit.size() != 0 || swt_out !== 4'h2) begin
            n_fail++;
            $display("FAIL relbounce_second: got swt_out=%h pending=%0d idle_ok=%0d, required 2 0 1",
                     swt_out, q_digit.size(), ok);
        end
    endtask

    task automatic test_reset_mid_press;
        bit ok;
        swt_in = 4'h8;
        tick(2);
        btn_n = 1'b0;
        tick(6);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rstpress_busy_before: got %b, required 1", busy); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (b_out !== 1'b0 || swt_out !== 4'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstpress_clear: got b_out=%b swt_out=%h busy=%b, required 0 0 0", b_out, swt_out, busy);
        end
        tick(2);
        rst = 1'b1;
        push_exp(4'h8, cyc + LAT);
        tick(20);
        n_cmp++;
        if (busy !== 1'b1 || swt_out !== 4'h8) begin
            n_fail++;
            $display("FAIL rstheld_before: got busy=%b swt_out=%h, required 1 8", busy, swt_out);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (b_out !== 1'b0 || swt_out !== 4'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstheld_clear: got b_out=%b swt_out=%h busy=%b, required 0 0 0", b_out, swt_out, busy);
        end
        tick(2);
        rst = 1'b1;
        push_exp(4'h8, cyc + LAT);
        tick(30);
        btn_n = 1'b1;
        wait_idle(ok);
        n_cmp++;
        if (!ok || q_digit.size() != 0 || swt_out !== 4'h8) begin
            n_fail++;
            $display("FAIL rstheld_after: got swt_out=%h pending=%0d idle_ok=%0d, required 8 0 1",
                     swt_out, q_digit.size(), ok);
        end
    endtask

`ifdef ENTRY_ECHO_EN
    task automatic test_echo;
        bit ok;
        rst = 1'b0;
        tick(2);
        n_cmp++;
        if (echo !== 16'h0000 || digit_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL echo_reset: got echo=%h digit_cnt=%0d, required 0000 0", echo, digit_cnt);
        end
        rst = 1'b1;
        tick(2);
        for (int d = 1; d <= 4; d++) begin
            press_release(4'(d), 15, ok);
        end
        n_cmp++;
        if (!ok || echo !== 16'h1234 || digit_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL echo_four: got echo=%h digit_cnt=%0d idle_ok=%0d, required 1234 4 1", echo, digit_cnt, ok);
        end
        press_release(4'h5, 15, ok);
        n_cmp++;
        if (!ok || echo !== 16'h0005 || digit_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL echo_fifth: got echo=%h digit_cnt=%0d idle_ok=%0d, required 0005 1 1", echo, digit_cnt, ok);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_switch_change();
        test_release_bounce();
        test_reset_mid_press();
`ifdef ENTRY_ECHO_EN
        test_echo();
`endif
        tick(5);
        n_cmp++;
        if (q_digit.size() != 0) begin
            n_fail++;
            $display("FAIL final_pending: %0d expected strobes never seen, required 0", q_digit.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_entry_conditioner
`default_nettype wire
